// File: rtl/rr_vc_token_arbiter.sv
// Multi-VN round-robin VC arbiter. Each VN has its own token and a registered, handshaked grant.
// Optional packet locking (grant held until the tail flit is accepted) is enabled by RR_PKT_LOCK_EN.

module rr_vc_token_arbiter_vn #(
    parameter int NUM_VC = 4,
    parameter int BW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_VC-1:0] req,
    input  logic              accept,
    input  logic              tail_in,
    output logic [NUM_VC-1:0] gnt,
    output logic              gnt_vld,
    output logic [BW-1:0]     gnt_idx,
    output logic [BW-1:0]     token
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1
`ifdef RR_PKT_LOCK_EN
        , LOCK = 2'd2
`endif
    } state_t;

    state_t state;

    // First set bit of r, scanning from p upward and wrapping at NUM_VC.
    function automatic logic [BW-1:0] sel_fn(input logic [NUM_VC-1:0] r, input logic [BW-1:0] p);
        logic [BW-1:0] s;
        logic          hit;
        int            k;
        s   = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            k = (int'(p) + i) % NUM_VC;
            if (!hit && r[k]) begin
                s   = k[BW-1:0];
                hit = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [NUM_VC-1:0] onehot(input logic [BW-1:0] idx);
        logic [NUM_VC-1:0] o;
        for (int i = 0; i < NUM_VC; i++)
            o[i] = (int'(idx) == i);
        return o;
    endfunction

    logic          req_any;
    logic          held;
    logic [BW:0]   idx_w;
    logic [BW-1:0] nt;
    logic [BW-1:0] sel_tok;
    logic [BW-1:0] sel_nt;
    logic          rel;
    logic          drop;

    assign req_any = |req;
    assign held    = |(req & gnt);
    // Widen before comparing so a non-power-of-two NUM_VC wraps at NUM_VC, not at 2**BW.
    assign idx_w   = {1'b0, gnt_idx};
    assign nt      = (idx_w == (BW+1)'(NUM_VC-1)) ? '0 : idx_w[BW-1:0] + 1'b1;
    assign sel_tok = sel_fn(req, token);
    assign sel_nt  = sel_fn(req, nt);

    always_comb begin
        rel  = 1'b0;
        drop = 1'b0;
        case (state)
            GNT: begin
`ifdef RR_PKT_LOCK_EN
                rel  = accept & tail_in;
`else
                rel  = accept;
`endif
                drop = !accept && !held;
            end
`ifdef RR_PKT_LOCK_EN
            LOCK: rel = accept & tail_in;
`endif
            default: ;
        endcase
    end

`ifndef RR_PKT_LOCK_EN
    logic unused_tail;
    assign unused_tail = tail_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            token   <= '0;
        end else if (rel) begin
            token <= nt;
            if (req_any) begin
                // Back-to-back re-arbitration from the advanced token; winner gets lowest priority.
                gnt     <= onehot(sel_nt);
                gnt_idx <= sel_nt;
                gnt_vld <= 1'b1;
                state   <= GNT;
            end else begin
                gnt     <= '0;
                gnt_idx <= '0;
                gnt_vld <= 1'b0;
                state   <= IDLE;
            end
        end else if (drop) begin
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            state   <= IDLE;
        end else if (state == IDLE && req_any) begin
            gnt     <= onehot(sel_tok);
            gnt_idx <= sel_tok;
            gnt_vld <= 1'b1;
            state   <= GNT;
        end
`ifdef RR_PKT_LOCK_EN
        else if (state == GNT && accept) begin
            state <= LOCK;
        end
`endif
    end

endmodule

module rr_vc_token_arbiter #(
    parameter int NUM_VC = 4,
    parameter int NUM_VN = 3,
    localparam int bits_VC = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_VN*NUM_VC-1:0]  req,
    input  logic [NUM_VN-1:0]         accept,
    input  logic [NUM_VN-1:0]         tail_in,
    output logic [NUM_VN*NUM_VC-1:0]  gnt,
    output logic [NUM_VN-1:0]         gnt_vld,
    output logic [NUM_VN*bits_VC-1:0] gnt_idx,
    output logic [NUM_VN*bits_VC-1:0] token
);

    for (genvar vn = 0; vn < NUM_VN; vn++) begin : g_vn
        rr_vc_token_arbiter_vn #(
            .NUM_VC (NUM_VC),
            .BW     (bits_VC)
        ) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req[vn*NUM_VC +: NUM_VC]),
            .accept  (accept[vn]),
            .tail_in (tail_in[vn]),
            .gnt     (gnt[vn*NUM_VC +: NUM_VC]),
            .gnt_vld (gnt_vld[vn]),
            .gnt_idx (gnt_idx[vn*bits_VC +: bits_VC]),
            .token   (token[vn*bits_VC +: bits_VC])
        );
    end

endmodule

// File: tb/tb_rr_vc_token_arbiter.sv
// Directed bench for rr_vc_token_arbiter (NUM_VC=4, NUM_VN=3): vector table plus lock/reset sequences.

module tb_rr_vc_token_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] req = '0;
    logic [2:0]  accept = '0;
    logic [2:0]  tail_in = '0;
    logic [11:0] gnt;
    logic [2:0]  gnt_vld;
    logic [5:0]  gnt_idx;
    logic [5:0]  token;

    int total = 0;
    int bad   = 0;

    rr_vc_token_arbiter #(.NUM_VC(4), .NUM_VN(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .accept  (accept),
        .tail_in (tail_in),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .token   (token)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] req;
        logic [2:0]  acc;
        logic [11:0] gnt;
        logic [2:0]  vld;
        logic [5:0]  idx;
        logic [5:0]  tok;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [11:0] eg, input logic [2:0] ev,
                           input logic [5:0] ei, input logic [5:0] et);
        chk({nm, " gnt"}, gnt, eg);
        chk({nm, " gnt_vld"}, {9'd0, gnt_vld}, {9'd0, ev});
        chk({nm, " gnt_idx"}, {6'd0, gnt_idx}, {6'd0, ei});
        chk({nm, " token"}, {6'd0, token}, {6'd0, et});
    endtask

    task automatic drive(input logic [11:0] r, input logic [2:0] a, input logic [2:0] t);
        req     = r;
        accept  = a;
        tail_in = t;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [11:0] r, input logic [2:0] a, input logic [11:0] g,
                       input logic [2:0] v, input logic [5:0] i, input logic [5:0] t);
        vec_t e;
        e.req = r; e.acc = a; e.gnt = g; e.vld = v; e.idx = i; e.tok = t;
        tbl.push_back(e);
    endtask

    initial begin
        // Idle with no request, then VN0 rotation with accept held high (first accept ignored).
        add(12'h000, 3'b000, 12'h000, 3'b000, 6'h00, 6'h00);
        add(12'h00F, 3'b001, 12'h001, 3'b001, 6'h00, 6'h00);
        add(12'h00F, 3'b001, 12'h002, 3'b001, 6'h01, 6'h01);
        add(12'h00F, 3'b001, 12'h004, 3'b001, 6'h02, 6'h02);
        add(12'h00F, 3'b001, 12'h008, 3'b001, 6'h03, 6'h03);
        add(12'h00F, 3'b001, 12'h001, 3'b001, 6'h00, 6'h00);
        add(12'h00F, 3'b001, 12'h002, 3'b001, 6'h01, 6'h01);
        add(12'h000, 3'b001, 12'h000, 3'b000, 6'h00, 6'h02);
        // Walk token to 3, then skip-and-wrap with req=0101.
        add(12'h004, 3'b000, 12'h004, 3'b001, 6'h02, 6'h02);
        add(12'h000, 3'b001, 12'h000, 3'b000, 6'h00, 6'h03);
        add(12'h005, 3'b000, 12'h001, 3'b001, 6'h00, 6'h03);
        add(12'h005, 3'b001, 12'h004, 3'b001, 6'h02, 6'h01);
        add(12'h000, 3'b001, 12'h000, 3'b000, 6'h00, 6'h03);
        // Sticky grant on idx 1 for five cycles, then withdrawal.
        add(12'h002, 3'b000, 12'h002, 3'b001, 6'h01, 6'h03);
        for (int i = 0; i < 5; i++)
            add(12'h00F, 3'b000, 12'h002, 3'b001, 6'h01, 6'h03);
        add(12'h00D, 3'b000, 12'h000, 3'b000, 6'h00, 6'h03);
        // VN independence and simultaneous accepts.
        add(12'h402, 3'b000, 12'h402, 3'b101, 6'h21, 6'h03);
        add(12'h802, 3'b100, 12'h802, 3'b101, 6'h31, 6'h33);
        add(12'h812, 3'b100, 12'h812, 3'b111, 6'h31, 6'h03);
        add(12'h000, 3'b111, 12'h000, 3'b000, 6'h00, 6'h06);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 12'h000, 3'b000, 6'h00, 6'h00);
        rst_n = 1'b1;

        // tail_in held high so every accept is a release in either build.
        foreach (tbl[k]) begin
            drive(tbl[k].req, tbl[k].acc, 3'b111);
            chk_all($sformatf("v%0d", k), tbl[k].gnt, tbl[k].vld, tbl[k].idx, tbl[k].tok);
        end

`ifdef RR_PKT_LOCK_EN
        drive(12'h00F, 3'b000, 3'b000);
        chk_all("lock grant", 12'h004, 3'b001, 6'h02, 6'h06);
        drive(12'h00F, 3'b001, 3'b000);
        chk_all("lock flit1", 12'h004, 3'b001, 6'h02, 6'h06);
        drive(12'h00F, 3'b001, 3'b000);
        chk_all("lock flit2", 12'h004, 3'b001, 6'h02, 6'h06);
        drive(12'h000, 3'b000, 3'b000);
        chk_all("lock withdraw", 12'h004, 3'b001, 6'h02, 6'h06);
        drive(12'h00F, 3'b001, 3'b001);
        chk_all("lock tail", 12'h008, 3'b001, 6'h03, 6'h07);
        drive(12'h000, 3'b001, 3'b001);
        chk_all("lock release", 12'h000, 3'b000, 6'h00, 6'h04);
`else
        drive(12'h00F, 3'b000, 3'b000);
        chk_all("nolock grant", 12'h004, 3'b001, 6'h02, 6'h06);
        drive(12'h00F, 3'b001, 3'b000);
        chk_all("nolock accept", 12'h008, 3'b001, 6'h03, 6'h07);
        drive(12'h000, 3'b001, 3'b000);
        chk_all("nolock release", 12'h000, 3'b000, 6'h00, 6'h04);
`endif

        // Asynchronous reset in the middle of a grant.
        drive(12'h00F, 3'b000, 3'b000);
        chk_all("pre-reset", 12'h001, 3'b001, 6'h00, 6'h04);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 12'h000, 3'b000, 6'h00, 6'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(12'h000, 3'b000, 3'b000);
        drive(12'h000, 3'b001, 3'b001);
        chk_all("post-reset idle", 12'h000, 3'b000, 6'h00, 6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
